// File: rtl/serial_add_pkg.sv
// Definitions shared by the bit-serial adder slice: feeder FSM states and default geometry.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } feeder_state_e;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PAD_CYCLES = 2;

endpackage

// File: rtl/serial_operand_feeder.sv
// Latches an operand pair, shifts it LSB-first into the serial adder, then appends flush cycles.
// Build option: define SIGN_EXT_EN to drive the latched operand MSBs during flush instead of 0.
module serial_operand_feeder
  import serial_add_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PAD_CYCLES = DEF_PAD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             flush,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a pair is taken on any rising edge where in_valid && in_ready.
  // in_ready is high only while idle; in_valid at other times is ignored, never queued.

  localparam int CW = $clog2(WIDTH + PAD_CYCLES + 1);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [CW-1:0] P_C = CW'(PAD_CYCLES);

  feeder_state_e    state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             a_q, b_q, bit_valid_q, flush_q;
  logic             frame_start_q, frame_last_q, busy_q, in_ready_q;
  logic             pad_a, pad_b;

`ifdef SIGN_EXT_EN
  logic msb_a_q, msb_b_q;
  assign pad_a = msb_a_q;
  assign pad_b = msb_b_q;
`else
  assign pad_a = 1'b0;
  assign pad_b = 1'b0;
`endif

  // cnt_q counts data bits emitted in SHIFT, flush bits emitted in FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sa_q          <= '0;
      sb_q          <= '0;
      a_q           <= 1'b0;
      b_q           <= 1'b0;
      bit_valid_q   <= 1'b0;
      flush_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b0;
`ifdef SIGN_EXT_EN
      msb_a_q       <= 1'b0;
      msb_b_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q         <= '0;
          a_q           <= 1'b0;
          b_q           <= 1'b0;
          bit_valid_q   <= 1'b0;
          flush_q       <= 1'b0;
          frame_start_q <= 1'b0;
          frame_last_q  <= 1'b0;
          busy_q        <= 1'b0;
          if (in_valid && in_ready_q) begin
            state_q       <= ST_SHIFT;
            sa_q          <= op_a >> 1;
            sb_q          <= op_b >> 1;
            a_q           <= op_a[0];
            b_q           <= op_b[0];
            bit_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            frame_last_q  <= (WIDTH == 1) && (PAD_CYCLES == 0);
            busy_q        <= 1'b1;
            in_ready_q    <= 1'b0;
            cnt_q         <= CW'(1);
`ifdef SIGN_EXT_EN
            msb_a_q       <= op_a[WIDTH-1];
            msb_b_q       <= op_b[WIDTH-1];
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          frame_start_q <= 1'b0;
          if (cnt_q != W_C) begin
            a_q          <= sa_q[0];
            b_q          <= sb_q[0];
            sa_q         <= sa_q >> 1;
            sb_q         <= sb_q >> 1;
            cnt_q        <= cnt_q + CW'(1);
            frame_last_q <= (PAD_CYCLES == 0) && (cnt_q == W_C - CW'(1));
          end else if (PAD_CYCLES > 0) begin
            state_q      <= ST_FLUSH;
            a_q          <= pad_a;
            b_q          <= pad_b;
            bit_valid_q  <= 1'b0;
            flush_q      <= 1'b1;
            cnt_q        <= CW'(1);
            frame_last_q <= (PAD_CYCLES == 1);
          end else begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q != P_C) begin
            cnt_q        <= cnt_q + CW'(1);
            frame_last_q <= (cnt_q == P_C - CW'(1));
          end else begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            flush_q      <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign bit_valid   = bit_valid_q;
  assign flush       = flush_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign busy        = busy_q;
  assign in_ready    = in_ready_q;
  assign dbg_state   = state_q;

endmodule
